// File: rtl/data_mem_port.sv
// Load/store engine between the pipeline MEM stage and a RAM2Kx32 data memory.
// Sub-word stores are done as read-modify-write because the RAM has no byte enables.
module data_mem_port #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic                  mem_oen,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [31:0]           mem_d,
  input  logic [31:0]           mem_q
);

  localparam int TAG_LSB = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, ERR, WR, RD, MRG, RSP} state_t;

  state_t                state, next_state;
  logic                  accept, req_bad;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  we_q, uns_q;
  logic [31:0]           mem_d_hold;
  logic [4:0]            lane_shift;
  logic [31:0]           shifted, lane_mask, merged, load_val;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'b11) req_bad = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
    if (req_addr[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB]) req_bad = 1'b1;
  end

  // Lane position within the word; halfword requests are already aligned so addr[0]=0.
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    shifted    = mem_q >> lane_shift;
    case (size_q)
      2'b00: begin
        lane_mask = 32'h0000_00FF << lane_shift;
        load_val  = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        lane_mask = 32'h0000_FFFF << lane_shift;
        load_val  = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        load_val  = mem_q;
      end
    endcase
    merged = (mem_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_cen    = 1'b1;
    mem_wen    = 1'b1;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                            next_state = ERR;
          else if (req_we && req_size == 2'b10)   next_state = WR;
          else                                    next_state = RD;
        end
      end
      ERR: next_state = IDLE;
      WR: begin
        mem_cen    = 1'b0;
        mem_wen    = 1'b0;
        next_state = RSP;
      end
      RD: begin
        mem_cen    = 1'b0;
        next_state = MRG;
      end
      MRG: begin
        mem_cen    = ~we_q;
        mem_wen    = ~we_q;
        next_state = RSP;
      end
      RSP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, write-data hold register and the response data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      mem_d_hold <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr[ADDR_WIDTH+1:0];
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        if (req_bad)
          resp_rdata <= '0;
        else if (req_we && req_size == 2'b10)
          mem_d_hold <= req_wdata;
      end
      if (state == WR) resp_rdata <= '0;
      if (state == MRG) begin
        if (we_q) begin
          resp_rdata <= '0;
          mem_d_hold <= merged;
        end else begin
          resp_rdata <= load_val;
        end
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RSP) || (state == ERR);
  assign resp_err   = (state == ERR);
  assign mem_oen    = 1'b0;
  assign mem_a      = addr_q[ADDR_WIDTH+1:2];
  assign mem_d      = (state == MRG && we_q) ? merged : mem_d_hold;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed self-checking bench for data_mem_port with a behavioural RAM2Kx32 attached.
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_cen, mem_wen, mem_oen;
  logic [10:0] mem_a;
  logic [31:0] mem_d, mem_q;

  logic [31:0] ram [0:2047];

  int          checks = 0;
  int          failures = 0;
  int          lat, nrd, nwr;
  logic [31:0] got_rdata;
  logic        got_err;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];
  vec_t errs [4];

  always #5 clk = ~clk;

  data_mem_port #(.ADDR_WIDTH(11), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  // Behavioural RAM: read data appears in the cycle after the read edge.
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) ram[mem_a] <= mem_d;
      else          mem_q <= ram[mem_a];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic done;
    @(negedge clk);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    checkOutput("ready_before_req", req_ready, 1);
    @(posedge clk);
    lat  = 0;
    nrd  = 0;
    nwr  = 0;
    done = 1'b0;
    got_rdata = 32'hxxxx_xxxx;
    got_err   = 1'bx;
    while (!done && lat < 10) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (!mem_cen) begin
        if (!mem_wen) nwr++;
        else          nrd++;
      end
      if (resp_valid) begin
        done      = 1'b1;
        got_rdata = resp_rdata;
        got_err   = resp_err;
      end
    end
    if (!done) checkOutput("resp_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx, nresp, overlap, cyc;
    logic found, saw_resp;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_rdata", resp_rdata, 0);
    checkOutput("rst_cen", mem_cen, 1);
    checkOutput("rst_wen", mem_wen, 1);
    checkOutput("rst_oen", mem_oen, 0);
    checkOutput("rst_mem_a", {21'h0, mem_a}, 0);
    checkOutput("rst_mem_d", mem_d, 0);
    rst_n = 1'b1;

    // T1: word store then word load
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checkOutput("t1_st_lat", lat, 2);
    checkOutput("t1_st_err", got_err, 0);
    checkOutput("t1_st_nwr", nwr, 1);
    checkOutput("t1_st_nrd", nrd, 0);
    checkOutput("t1_ram", ram[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("t1_ld_lat", lat, 3);
    checkOutput("t1_ld_err", got_err, 0);
    checkOutput("t1_ld_rdata", got_rdata, 32'hDEADBEEF);

    // T2: byte store read-modify-write, then signed and unsigned byte loads
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    checkOutput("t2_st_lat", lat, 3);
    checkOutput("t2_st_nrd", nrd, 1);
    checkOutput("t2_st_nwr", nwr, 1);
    checkOutput("t2_st_rdata_clr", got_rdata, 0);
    checkOutput("t2_ram", ram[4], 32'hDEADAAEF);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    checkOutput("t2_ldb_s", got_rdata, 32'hFFFFFFAA);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    checkOutput("t2_ldb_u", got_rdata, 32'h000000AA);

    // T3: halfword store in the upper lane, halfword and word loads
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
    checkOutput("t3_st_lat", lat, 3);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checkOutput("t3_ldh_hi", got_rdata, 32'h00001234);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("t3_ldw", got_rdata, 32'h1234AAEF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    checkOutput("t3_ldh_lo_s", got_rdata, 32'hFFFFAAEF);

    // T4: error responses, no RAM activity
    errs[0] = '{1'b0, 2'b10, 1'b0, 32'h13,   32'h0, 32'h0};
    errs[1] = '{1'b1, 2'b01, 1'b0, 32'h11,   32'h5555, 32'h0};
    errs[2] = '{1'b0, 2'b11, 1'b0, 32'h10,   32'h0, 32'h0};
    errs[3] = '{1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(errs[i].we, errs[i].size, errs[i].uns, errs[i].addr, errs[i].wdata);
      checkOutput($sformatf("t4_lat%0d", i), lat, 1);
      checkOutput($sformatf("t4_err%0d", i), got_err, 1);
      checkOutput($sformatf("t4_rdata%0d", i), got_rdata, 0);
      checkOutput($sformatf("t4_ramops%0d", i), nrd + nwr, 0);
    end
    checkOutput("t4_ram_kept", ram[4], 32'h1234AAEF);

    // T5: req_valid held high across back-to-back requests
    vecs[0] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, 32'h0};
    vecs[1] = '{1'b1, 2'b10, 1'b0, 32'h24, 32'h22222222, 32'h0};
    vecs[2] = '{1'b1, 2'b00, 1'b0, 32'h25, 32'h00000033, 32'h0};
    vecs[3] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11111111};
    vecs[4] = '{1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h22223322};
    vecs[5] = '{1'b0, 2'b00, 1'b1, 32'h25, 32'h0, 32'h00000033};
    idx = 0; nresp = 0; overlap = 0; cyc = 0;
    while ((idx < 6 || nresp < 6) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        if (nresp < 6) checkOutput($sformatf("t5_rdata%0d", nresp), resp_rdata, vecs[nresp].exp);
        nresp++;
        if (req_ready) overlap++;
      end
      if (idx < 6) begin
        req_we = vecs[idx].we; req_size = vecs[idx].size; req_unsigned = vecs[idx].uns;
        req_addr = vecs[idx].addr; req_wdata = vecs[idx].wdata;
        req_valid = 1'b1;
        if (req_ready) idx++;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk) if (resp_valid) nresp++;
    checkOutput("t5_accepted", idx, 6);
    checkOutput("t5_responses", nresp, 6);
    checkOutput("t5_ready_overlap", overlap, 0);
    checkOutput("t5_ram8", ram[8], 32'h11111111);
    checkOutput("t5_ram9", ram[9], 32'h22223322);

    // T6: reset while the merge write of a byte store is pending
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (!mem_cen && !mem_wen) found = 1'b1;
    end
    checkOutput("t6_reached_merge", found, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_cen_abort", mem_cen, 1);
    checkOutput("t6_wen_abort", mem_wen, 1);
    saw_resp = 1'b0;
    repeat (2) @(negedge clk) if (resp_valid) saw_resp = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk) if (resp_valid) saw_resp = 1'b1;
    checkOutput("t6_no_resp", saw_resp, 0);
    checkOutput("t6_ready", req_ready, 1);
    checkOutput("t6_ram_kept", ram[4], 32'h1234AAEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
